mult_div: RTL and testbench
===========================

# mult_div

Multi-cycle integer multiply/divide unit that answers the EX stage's MULT/MULTU/DIV/DIVU requests. EX presents `funct` and operands, then holds them stable while its `stall_request` is high (`stall_request = !done` for those functs). This block iterates one bit per clock, then returns a 64-bit HI:LO result with a `done` strobe. EX writes HI/LO from `result` in the cycle `done` is high.

## Interface
- No parameters; widths come from `bus.v` (`DATA_BUS` = 32, `MULT_DIV_BUS` = 64, `FUNCT_BUS` = 6). Encodings come from `funct.v`.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, asynchronous, active-low.
- `funct`  in  6  — EX-stage funct; only `FUNCT_MULT/MULTU/DIV/DIVU` start work.
- `operand_1`  in  32  — multiplicand / dividend.
- `operand_2`  in  32  — multiplier / divisor.
- `stall`  in  1  — pipeline stalled by another source; EX will not advance this cycle.
- `flush`  in  1  — pipeline flush; abort any operation.
- `done`  out  1  — result valid; registered (state == DONE).
- `result`  out  64  — {HI, LO}; registered, held between operations.

## Operation
- **States:** IDLE, BUSY, DONE. Counter `cnt` is 6 bits.
- **IDLE:**
  - If `funct` is MULT/DIV-class and `flush` = 0, capture on the clock edge:
    - operand magnitudes (|x| for signed ops; raw for unsigned);
    - `neg_q` = op1[31] ^ op2[31] for signed ops, else 0;
    - `neg_r` = op1[31] for DIV, else 0.
  - Then go BUSY with `cnt` = 0.
  - DIV/DIVU with `operand_2` = 0 skips BUSY and goes straight to DONE with `result` = {operand_1, 32'hFFFFFFFF}.
- **BUSY, multiply (shift-add):**
  - 64-bit product register; low half is initialised with the multiplier.
  - Each cycle: if prod[0], add the multiplicand to prod[63:32] with a 33-bit carry; then shift the 65-bit value right by 1.
- **BUSY, divide (restoring):**
  - 33-bit remainder; quotient register initialised with the dividend.
  - Each cycle: shift {rem, quo} left by 1, trial-subtract the divisor; if non-negative, keep the difference and set quo[0].
- **BUSY exit:** after 32 iterations (`cnt` = 31 on the edge), go DONE. On that edge `result` loads the sign-corrected value:
  - MULT: 64-bit two's-complement negate if `neg_q`.
  - DIV: LO = quotient, negated if `neg_q`; HI = remainder, negated if `neg_r`.
- **DONE:** `done` = 1. If `stall` = 1, remain in DONE with `result` held; otherwise go IDLE.
- **flush:** from any state, go IDLE next edge; `result` is not updated and `done` drops.
- **Reset (async, any time):** state = IDLE, `cnt` = 0, `done` = 0, `result` = 0, all datapath registers = 0.
- **Arithmetic rules:**
  - 0x80000000 magnitude is handled as unsigned 2^31.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no trap).
  - Unsigned ops never negate.
- Non-MULT/DIV `funct` in IDLE: no action, `done` stays 0.

## Timing
- Issue cycle C1 = first cycle `funct` is MULT/DIV-class in IDLE. BUSY spans C2–C33. `done` = 1 in C34, and `result` is valid from C34.
- EX therefore stalls C1–C33 and advances at the end of C34.
- Divide-by-zero: `done` = 1 in C2.
- A back-to-back MULT/DIV arriving in the cycle after DONE exits starts a new operation from IDLE. There are no dead cycles beyond the state transition.
- `flush` takes priority over `stall` and over operation start when asserted together.
- Operands and `funct` are sampled only in IDLE. Changes during BUSY/DONE are ignored.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, issued in C1 -> `done` = 1 in C34 only, `result` = 0xFFFFFFFE_00000001.
- MULT -3 (0xFFFFFFFD) × 7 -> `result` = 0xFFFFFFFF_FFFFFFEB. MULT 0x80000000 × 0x80000000 -> 0x40000000_00000000.
- DIV -7 / 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFD. DIVU 7 / 2 -> HI = 1, LO = 3. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- DIV 0x12345678 / 0 -> `done` in C2, `result` = 0x12345678_FFFFFFFF.
- Abort cases:
  - `flush` asserted in C10 -> `done` never rises, `result` keeps its prior value, state = IDLE in C11.
  - Async `rst` low mid-BUSY -> `done` = 0 and `result` = 0 immediately.
- `stall` = 1 during C34–C36 -> `done` held high for 4 cycles with `result` stable. A following MULTU 2 × 3 in the next IDLE cycle -> `result` = 6, with `done` 33 cycles later.

Source files
------------

// File: rtl/mult_div.sv
// rtl/mult_div.sv - multi-cycle MULT/MULTU/DIV/DIVU unit returning {HI, LO}

module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        stall,
    input  logic        flush,
    output logic        done,
    output logic [63:0] result
);

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q, prod_d;
    logic [32:0] rem_q, rem_d;
    logic [63:0] result_q, result_d;

    // Request decode; magnitudes of 0x80000000 read as unsigned 2^31.
    logic        req_div, req_signed, req_md, start, div_zero, last_iter;
    logic [31:0] abs_1, abs_2;

    assign req_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    assign req_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign req_md     = req_div || (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign start      = req_md && !flush;
    assign div_zero   = req_div && (operand_2 == 32'd0);
    assign abs_1      = (req_signed && operand_1[31]) ? -operand_1 : operand_1;
    assign abs_2      = (req_signed && operand_2[31]) ? -operand_2 : operand_2;
    assign last_iter  = (cnt_q == 6'd31);

    // One shift-add multiply step: conditional add into the high half, then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_final;

    assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign mul_next  = {mul_sum, prod_q[31:1]};
    assign mul_final = neg_quo_q ? -mul_next : mul_next;

    // One restoring divide step: shift {rem, quo} left, keep the trial difference if it fits.
    logic [32:0] div_shift, div_diff, div_rem_next;
    logic        div_ok;
    logic [31:0] div_quo_next, quo_final, rem_final;

    assign div_shift    = {rem_q[31:0], prod_q[31]};
    assign div_ok       = rem_q[32] || (div_shift >= {1'b0, mcand_q});
    assign div_diff     = div_shift - {1'b0, mcand_q};
    assign div_rem_next = div_ok ? div_diff : div_shift;
    assign div_quo_next = {prod_q[30:0], div_ok};
    assign quo_final    = neg_quo_q ? -div_quo_next : div_quo_next;
    assign rem_final    = neg_rem_q ? -div_rem_next[31:0] : div_rem_next[31:0];

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= 32'd0;
            prod_q    <= 64'd0;
            rem_q     <= 33'd0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    // Next-state logic; flush wins over stall and over a new start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = div_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush || !stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: done is high for every cycle spent in DONE.
    always_comb begin
        done = (state_q == DONE);
    end

    // Datapath updates: operand capture in IDLE, one iteration per BUSY cycle, result on the last.
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        result_d  = result_q;
        if (state_q == IDLE && start) begin
            cnt_d     = 6'd0;
            is_div_d  = req_div;
            neg_quo_d = req_signed && (operand_1[31] ^ operand_2[31]);
            neg_rem_d = (funct == FUNCT_DIV) && operand_1[31];
            rem_d     = 33'd0;
            if (req_div) begin
                mcand_d = abs_2;
                prod_d  = {32'd0, abs_1};
            end else begin
                mcand_d = abs_1;
                prod_d  = {32'd0, abs_2};
            end
            if (div_zero) begin
                result_d = {operand_1, 32'hFFFF_FFFF};
            end
        end else if (state_q == BUSY && !flush) begin
            cnt_d = cnt_q + 6'd1;
            if (is_div_q) begin
                rem_d  = div_rem_next;
                prod_d = {32'd0, div_quo_next};
            end else begin
                prod_d = mul_next;
            end
            if (last_iter) begin
                result_d = is_div_q ? {rem_final, quo_final} : mul_final;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - directed self-checking bench for mult_div

module tb_mult_div;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_NOP   = 6'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        stall;
    logic        flush;
    logic        done;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_div dut (
        .clk       (clk),
        .rst       (rst),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .stall     (stall),
        .flush     (flush),
        .done      (done),
        .result    (result)
    );

    task automatic test_reset();
        rst = 1'b0; funct = F_NOP; operand_1 = 32'd0; operand_2 = 32'd0;
        stall = 1'b0; flush = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue in C1 as EX would, hold until done, check the done cycle and the result.
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_cyc);
        int cyc;
        @(posedge clk); #1;
        funct = f; operand_1 = a; operand_2 = b;
        cyc = 1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_c1 got=%b exp=0", name, done); end
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, exp_cyc); end
        n_checks++;
        if (result !== exp_res) begin n_fail++; $display("FAIL %s result got=%h exp=%h", name, result, exp_res); end
        funct = F_NOP; operand_1 = 32'd0; operand_2 = 32'd0;
    endtask

    task automatic test_multiply();
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34);
        run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 34);
        run_op("mult_min_sq", F_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 34);
    endtask

    task automatic test_divide();
        run_op("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("divu_7by2", F_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 34);
        run_op("div_min_by_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34);
        run_op("div_by_zero", F_DIV, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 2);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] held;
        @(posedge clk); #1;
        funct = F_DIVU; operand_1 = 32'd7; operand_2 = 32'd2;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != 34) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=34", cyc); end
        stall = 1'b1;
        held = result;
        for (int c = 35; c <= 37; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_held_c%0d got=%b exp=1", c, done); end
            n_checks++;
            if (result !== 64'h0000_0001_0000_0003) begin
                n_fail++; $display("FAIL b2b_result_held_c%0d got=%h exp=%h", c, result, held);
            end
        end
        stall = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_c38 got=%b exp=0", done); end
        funct = F_MULTU; operand_1 = 32'd2; operand_2 = 32'd3;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != 34) begin n_fail++; $display("FAIL b2b_second_done got=%0d exp=34", cyc); end
        n_checks++;
        if (result !== 64'd6) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=6", result); end
        funct = F_NOP; operand_1 = 32'd0; operand_2 = 32'd0;
    endtask

    // Flush in C10; a divide-by-zero issued in C11 only completes in C12 if the unit is IDLE in C11.
    task automatic test_flush();
        int rises;
        @(posedge clk); #1;
        funct = F_MULTU; operand_1 = 32'h0000_1234; operand_2 = 32'h10;
        rises = 0;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) rises++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (done === 1'b1) rises++;
        n_checks++;
        if (rises != 0) begin n_fail++; $display("FAIL flush_done_rose got=%0d exp=0", rises); end
        n_checks++;
        if (result !== 64'd6) begin n_fail++; $display("FAIL flush_result_kept got=%h exp=6", result); end
        funct = F_DIVU; operand_1 = 32'hCAFE_BABE; operand_2 = 32'd0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL flush_idle_c11 done got=%b exp=1", done); end
        n_checks++;
        if (result !== 64'hCAFE_BABE_FFFF_FFFF) begin
            n_fail++; $display("FAIL flush_idle_c11 result got=%h exp=cafebabeffffffff", result);
        end
        funct = F_NOP; operand_1 = 32'd0; operand_2 = 32'd0;
    endtask

    task automatic test_flush_priority();
        int rises;
        run_op("div9_zero", F_DIVU, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 2);
        stall = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall done got=%b exp=0", done); end
        stall = 1'b0;
        funct = F_MULT; operand_1 = 32'd5; operand_2 = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; funct = F_ADD;
        rises = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) rises++;
        end
        n_checks++;
        if (rises != 0) begin n_fail++; $display("FAIL flush_over_start_or_nonmd got=%0d exp=0", rises); end
        n_checks++;
        if (result !== 64'h0000_0009_FFFF_FFFF) begin
            n_fail++; $display("FAIL flush_over_start_result got=%h exp=00000009ffffffff", result);
        end
        funct = F_NOP;
    endtask

    task automatic test_async_reset();
        int rises;
        @(posedge clk); #1;
        funct = F_MULTU; operand_1 = 32'd5; operand_2 = 32'd5;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL async_rst_done got=%b exp=0", done); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL async_rst_result got=%h exp=0", result); end
        funct = F_NOP; operand_1 = 32'd0; operand_2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rises = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) rises++;
        end
        n_checks++;
        if (rises != 0) begin n_fail++; $display("FAIL async_rst_aborted got=%0d exp=0", rises); end
        run_op("mult_after_rst", F_MULT, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 34);
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_back_to_back();
        test_flush();
        test_flush_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
